// File: rtl/keypad_scanner_if.sv
// Keypad pins plus the debounced key/entry outputs; master is the scanner side.
interface keypad_scanner_if;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic        entry_clr;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] entry;

    modport master (
        input  row_in, entry_clr,
        output col_out, key_code, key_valid, key_held, entry
    );

    modport slave (
        output row_in, entry_clr,
        input  col_out, key_code, key_valid, key_held, entry
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner/debouncer feeding a 4-digit BCD entry register; KEYPAD_AUTO_REPEAT_EN adds held-key repeat.
// Latency: key_valid one cycle after the DEBOUNCE_SCANS-th matching frame; no backpressure (pulse outputs).
module keypad_scanner #(
    parameter int SCAN_DIV_BITS  = 11,
    parameter int DEBOUNCE_SCANS = 4
`ifdef KEYPAD_AUTO_REPEAT_EN
    ,
    parameter int REPEAT_DELAY   = 64,
    parameter int REPEAT_RATE    = 16
`endif
) (
    input logic              clk_fast,
    input logic              rst_n,
    keypad_scanner_if.master kp
);
    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;
    localparam logic [3:0] DS = 4'(DEBOUNCE_SCANS);

    logic [SCAN_DIV_BITS-1:0] presc;
    logic [1:0]  col_idx;
    logic [3:0]  col_q;
    logic [15:0] hits, frame_hits;
    logic        tick, frame_done;
    logic [1:0]  hit_cnt;
    logic [3:0]  hit_idx, hit_code;
    logic        none_hit, single_hit;

    state_t      state, state_n;
    logic [3:0]  cand, cand_n, cnt, cnt_n;
    logic        armed, armed_n, accept;
    logic [3:0]  code_q;
    logic        valid_q;
    logic [15:0] entry_q;

`ifdef KEYPAD_AUTO_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    logic [RPT_W-1:0] rpt_cnt, rpt_cnt_n, rpt_limit;
    logic             rpt_first, rpt_first_n;
    assign rpt_limit = rpt_first ? RPT_W'(REPEAT_DELAY) : RPT_W'(REPEAT_RATE);
`endif

    function automatic logic [3:0] map_code(input logic [3:0] idx);
        case (idx)
            4'd0:  map_code = 4'h1;  4'd1:  map_code = 4'h2;
            4'd2:  map_code = 4'h3;  4'd3:  map_code = 4'hA;
            4'd4:  map_code = 4'h4;  4'd5:  map_code = 4'h5;
            4'd6:  map_code = 4'h6;  4'd7:  map_code = 4'hB;
            4'd8:  map_code = 4'h7;  4'd9:  map_code = 4'h8;
            4'd10: map_code = 4'h9;  4'd11: map_code = 4'hC;
            4'd12: map_code = 4'h0;  4'd13: map_code = 4'hF;
            4'd14: map_code = 4'hE;  default: map_code = 4'hD;
        endcase
    endfunction

    assign tick       = &presc;
    assign frame_done = tick && (col_idx == 2'd3);

    // Hit bit index is row*4+col; the current column is merged in so the
    // final tick of a frame classifies all sixteen keys at once.
    always_comb begin
        frame_hits = hits;
        for (int r = 0; r < 4; r++)
            frame_hits[r*4 + int'(col_idx)] = ~kp.row_in[r];
    end

    always_comb begin
        hit_cnt = 2'd0;
        hit_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (frame_hits[i]) begin
                hit_cnt = (hit_cnt == 2'd0) ? 2'd1 : 2'd2;
                hit_idx = 4'(i);
            end
        end
    end

    assign none_hit   = (hit_cnt == 2'd0);
    assign single_hit = (hit_cnt == 2'd1);
    assign hit_code   = map_code(hit_idx);

    always_ff @(posedge clk_fast) begin
        if (!rst_n) begin
            presc   <= '0;
            col_idx <= 2'd0;
            col_q   <= 4'b1110;
            hits    <= '0;
        end else begin
            presc <= presc + 1'b1;
            if (tick) begin
                hits    <= frame_hits;
                col_idx <= col_idx + 2'd1;
                col_q   <= ~(4'b0001 << (col_idx + 2'd1));
            end
        end
    end

    // After reset the scanner stays disarmed until DEBOUNCE_SCANS empty
    // frames are seen, so a key held through reset is never reported.
    always_comb begin
        state_n = state;
        cand_n  = cand;
        cnt_n   = cnt;
        armed_n = armed;
        accept  = 1'b0;
`ifdef KEYPAD_AUTO_REPEAT_EN
        rpt_cnt_n   = rpt_cnt;
        rpt_first_n = rpt_first;
`endif
        if (frame_done) begin
            case (state)
                IDLE: begin
                    if (!armed) begin
                        if (!none_hit) cnt_n = 4'd0;
                        else if (cnt + 4'd1 == DS) begin
                            armed_n = 1'b1;
                            cnt_n   = 4'd0;
                        end else cnt_n = cnt + 4'd1;
                    end else if (single_hit) begin
                        state_n = DEBOUNCE;
                        cand_n  = hit_code;
                        cnt_n   = 4'd1;
                    end
                end
                DEBOUNCE: begin
                    if (single_hit && hit_code == cand) begin
                        if (cnt + 4'd1 == DS) begin
                            state_n = PRESSED;
                            cnt_n   = 4'd0;
                            accept  = 1'b1;
                        end else cnt_n = cnt + 4'd1;
                    end else if (single_hit) begin
                        cand_n = hit_code;
                        cnt_n  = 4'd1;
                    end else begin
                        state_n = IDLE;
                        cnt_n   = 4'd0;
                    end
                end
                PRESSED: begin
                    if (none_hit) begin
                        state_n = RELEASE;
                        cnt_n   = 4'd1;
                    end
`ifdef KEYPAD_AUTO_REPEAT_EN
                    else if (single_hit && hit_code == cand) begin
                        if (rpt_cnt + 1'b1 == rpt_limit) begin
                            accept      = 1'b1;
                            rpt_cnt_n   = '0;
                            rpt_first_n = 1'b0;
                        end else rpt_cnt_n = rpt_cnt + 1'b1;
                    end
`else
                    else state_n = PRESSED;
`endif
                end
                default: begin
                    if (!none_hit) begin
                        state_n = PRESSED;
                        cnt_n   = 4'd0;
                    end else if (cnt + 4'd1 == DS) begin
                        state_n = IDLE;
                        cnt_n   = 4'd0;
                    end else cnt_n = cnt + 4'd1;
                end
            endcase
        end
`ifdef KEYPAD_AUTO_REPEAT_EN
        if (state_n != PRESSED) begin
            rpt_cnt_n   = '0;
            rpt_first_n = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk_fast) begin
        if (!rst_n) begin
            state   <= IDLE;
            cand    <= 4'd0;
            cnt     <= 4'd0;
            armed   <= 1'b0;
            code_q  <= 4'd0;
            valid_q <= 1'b0;
`ifdef KEYPAD_AUTO_REPEAT_EN
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
`endif
        end else begin
            state   <= state_n;
            cand    <= cand_n;
            cnt     <= cnt_n;
            armed   <= armed_n;
            valid_q <= accept;
            if (accept) code_q <= cand;
`ifdef KEYPAD_AUTO_REPEAT_EN
            rpt_cnt   <= rpt_cnt_n;
            rpt_first <= rpt_first_n;
`endif
        end
    end

    always_ff @(posedge clk_fast) begin
        if (!rst_n || kp.entry_clr) entry_q <= '0;
        else if (valid_q) begin
            if (code_q <= 4'd9)       entry_q <= {entry_q[11:0], code_q};
            else if (code_q == 4'hC)  entry_q <= '0;
        end
    end

    assign kp.col_out   = col_q;
    assign kp.key_code  = code_q;
    assign kp.key_valid = valid_q;
    assign kp.key_held  = (state == PRESSED) || (state == RELEASE);
    assign kp.entry     = entry_q;
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 active-low matrix keypad and debounces it; the input-side counterpart of the multiplexed seven-segment display driver.
- Drives one column low at a time and samples the rows.
- Reports one debounced key press per physical press.
- Shifts decimal digits into a 16-bit 4-digit BCD entry register that feeds the display's BCD input directly.

Parameters:
SCAN_DIV_BITS, 11, prescaler width; scan tick every 2^SCAN_DIV_BITS clocks.
DEBOUNCE_SCANS, 4, consecutive identical full frames required to accept a press or a release (range 2..15).
REPEAT_DELAY, 64, frames held before first auto-repeat (KEYPAD_AUTO_REPEAT_EN only).
REPEAT_RATE, 16, frames between repeats (KEYPAD_AUTO_REPEAT_EN only).

Ports:
clk_fast  input  1  system clock
rst_n  input  1  synchronous, active-low reset
row_in  input  4  keypad rows, active low (pulled up externally)
col_out  output  4  keypad columns, one driven low at a time
entry_clr  input  1  synchronous clear of entry
key_code  output  4  code of last accepted key
key_valid  output  1  one-cycle pulse per accepted key
key_held  output  1  high while accepted key is still pressed
entry  output  16  four BCD digits, newest digit in [3:0]

Behaviour:
- Reset (rst_n low at a clk_fast edge): prescaler 0, column index 0, col_out=4'b1110, FSM IDLE, debounce count 0, key_code 0, key_valid 0, key_held 0, entry 0.
- Reset mid-press re-enters IDLE; the press is not reported until released and pressed again.
- Prescaler: free-running SCAN_DIV_BITS-bit counter. Tick = counter all ones (one cycle per wrap).
- On tick:
  - sample ~row_in into the hit bits for the current column;
  - advance column index mod 4; col_out = ~(1<<index), registered.
  - A column is driven for a full tick period before it is sampled.
- Frame = 4 ticks (columns 0..3). On the tick sampling column 3, classify the frame:
  - NONE: 0 hits;
  - SINGLE(code): exactly 1 hit;
  - MULTI: ≥2 hits (ghosting; treated as no valid key).
- Code map, (row, col0..3):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
- FSM, evaluated once per frame:
  - IDLE:
    - SINGLE(k) -> DEBOUNCE, cand=k, cnt=1.
  - DEBOUNCE:
    - SINGLE(cand) -> cnt+1; when cnt reaches DEBOUNCE_SCANS -> PRESSED and accept.
    - SINGLE(other) -> cand=other, cnt=1.
    - NONE or MULTI -> IDLE.
  - PRESSED (key_held=1):
    - NONE -> RELEASE, cnt=1.
    - anything else -> stay.
  - RELEASE (key_held=1):
    - NONE -> cnt+1; at DEBOUNCE_SCANS -> IDLE, key_held=0.
    - any hit -> PRESSED, cnt=0.
    - No second report.
- Accept:
  - key_code<=cand and key_valid=1 for exactly the one clk_fast cycle after the frame-completing tick.
  - key_held rises in the same cycle.
- Press latency: first valid frame F -> key_valid after frame F+DEBOUNCE_SCANS-1.
- Entry update, in the key_valid cycle:
  - code 0..9: entry<={entry[11:0],code}; the oldest digit drops off.
  - code C: entry<=0.
  - Other letters: entry unchanged, still reported.
  - entry_clr wins over a simultaneous digit: result 0.
- entry digits are always 0..9 (valid BCD).

Optional Feature:
KEYPAD_AUTO_REPEAT_EN:
- Defined:
  - In PRESSED with SINGLE(key_code), a frame counter starts at accept.
  - After REPEAT_DELAY frames: key_valid pulses again and entry updates as above.
  - Then a repeat every REPEAT_RATE frames.
  - Counter clears on leaving PRESSED.
  - A NONE frame pauses repeat (RELEASE).
- Undefined: exactly one key_valid per press; repeat logic and parameters absent.

Test Plan:
All with SCAN_DIV_BITS=2 (tick every 4 clocks, frame 16 clocks) and DEBOUNCE_SCANS=4.
1. Reset: rst_n low 3 cycles, rows 4'b1111 -> col_out=4'b1110, entry=0, key_valid/key_held 0. col_out rotates 1110->1101->1011->0111 every 4 clocks.
2. Clean press: model row1 low whenever col2 is driven (key 6) for 8 frames -> single key_valid after 4th frame, key_code=6, entry=16'h0006, key_held high. Release -> key_held low 4 frames later.
3. Bounce: key 5 toggled present/absent every frame for 6 frames, then held -> no pulse during toggling; one pulse 4 frames after stable, code 5.
4. Entry sequence: press 1,2,3,4,5 cleanly -> entry=16'h2345; press C -> entry=0; press A -> key_code=A, entry unchanged. entry_clr in the digit-accept cycle -> entry=0.
5. Ghosting: keys 1 and 2 held together 10 frames -> no key_valid, key_held 0. Then release 2 -> key 1 accepted after 4 frames.
6. Reset mid-press: reset during PRESSED with key held -> outputs reset, no key_valid until release ≥4 frames and re-press.
